// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two line requesters, the memory command/response port and status.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int LW = 128
);
  logic          req0_valid;
  logic [31:0]   req0_addr;
  logic          req0_ready;
  logic          req0_resp_valid;
  logic [LW-1:0] req0_rdata;

  logic          req1_valid;
  logic [31:0]   req1_addr;
  logic          req1_write;
  logic [LW-1:0] req1_wdata;
  logic          req1_ready;
  logic          req1_resp_valid;
  logic [LW-1:0] req1_rdata;

  logic          mem_is_input_valid;
  logic [31:0]   mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] mem_din;
  logic          mem_ready;
  logic          mem_is_output_valid;
  logic [LW-1:0] mem_dout;

  logic          busy;
  logic          grant_id;

  modport slave (
    input  req0_valid, req0_addr,
    input  req1_valid, req1_addr, req1_write, req1_wdata,
    input  mem_ready, mem_is_output_valid, mem_dout,
    output req0_ready, req0_resp_valid, req0_rdata,
    output req1_ready, req1_resp_valid, req1_rdata,
    output mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
    output busy, grant_id
  );

  modport master (
    output req0_valid, req0_addr,
    output req1_valid, req1_addr, req1_write, req1_wdata,
    output mem_ready, mem_is_output_valid, mem_dout,
    input  req0_ready, req0_resp_valid, req0_rdata,
    input  req1_ready, req1_resp_valid, req1_rdata,
    input  mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding line memory port.
// One transaction at a time: IDLE accepts, ISSUE presents the command, WAIT collects the reply.
module mem_arbiter #(
  parameter int LINE_SIZE = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int LW = 8 * LINE_SIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic          last_grant_reg;
  logic          grant_id_reg;
  logic [31:0]   addr_reg;
  logic          write_reg;
  logic [LW-1:0] wdata_reg;
  logic [1:0]    req_valid;
  logic [1:0]    ready;
  logic          accept;
  logic          accept_id;
  logic          done;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // On a tie the requester that did not own the last completed transaction wins.
  always_comb begin
    ready = 2'b00;
    if (reset && state_reg == IDLE) begin
      if (req_valid == 2'b11) ready = last_grant_reg ? 2'b01 : 2'b10;
      else                    ready = req_valid;
    end
  end

  assign accept    = |(req_valid & ready);
  assign accept_id = ready[1];
  assign done      = (state_reg == WAIT) && bus.mem_is_output_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (bus.mem_ready) state_next = WAIT;
      WAIT:    if (bus.mem_is_output_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg       <= '0;
      write_reg      <= 1'b0;
      wdata_reg      <= '0;
      grant_id_reg   <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      if (accept) begin
        addr_reg     <= accept_id ? bus.req1_addr : bus.req0_addr;
        write_reg    <= accept_id & bus.req1_write;
        wdata_reg    <= accept_id ? bus.req1_wdata : '0;
        grant_id_reg <= accept_id;
      end
      if (done) last_grant_reg <= grant_id_reg;
    end
  end

  // Per-requester response pulse and read-data holding register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic          resp_reg;
      logic [LW-1:0] rdata_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          resp_reg  <= 1'b0;
          rdata_reg <= '0;
        end else begin
          resp_reg <= done && (grant_id_reg == 1'(gi));
          if (done && !write_reg && (grant_id_reg == 1'(gi))) rdata_reg <= bus.mem_dout;
        end
      end
    end
  endgenerate

  assign bus.req0_ready         = ready[0];
  assign bus.req1_ready         = ready[1];
  assign bus.req0_resp_valid    = g_resp[0].resp_reg;
  assign bus.req1_resp_valid    = g_resp[1].resp_reg;
  assign bus.req0_rdata         = g_resp[0].rdata_reg;
  assign bus.req1_rdata         = g_resp[1].rdata_reg;
  assign bus.mem_is_input_valid = (state_reg == ISSUE);
  assign bus.mem_read           = (state_reg == ISSUE) && !write_reg;
  assign bus.mem_write          = (state_reg == ISSUE) && write_reg;
  assign bus.mem_addr           = addr_reg;
  assign bus.mem_din            = wdata_reg;
  assign bus.busy               = (state_reg != IDLE);
  assign bus.grant_id           = grant_id_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (request queues, round-robin rule, behavioural line memory).
module tb_mem_arbiter;
  localparam int LINE_SIZE = 16;
  localparam int LW = 8 * LINE_SIZE;

  typedef logic [LW-1:0] line_t;
  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        write;
    line_t       wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LW(LW)) bus();
  mem_arbiter #(.LINE_SIZE(LINE_SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  int    total = 0;
  int    passed = 0;
  int    cyc = 0;
  txn_t  q0[$];
  txn_t  q1[$];
  txn_t  served[$];
  txn_t  cur;
  int    phase = 0;       // 0 none outstanding, 1 command pending, 2 awaiting reply
  int    cnt = 0;
  int    lat_fixed = -1;
  int    rdy_pct = 100;
  bit    spur = 1'b0;
  bit    last = 1'b1;
  bit    resp_due = 1'b0;
  bit    resp_id = 1'b0;
  line_t exp_rd0 = '0;
  line_t exp_rd1 = '0;
  line_t mem_m [bit [31:0]];
  int    t_acc = 0, t_cmd = 0, t_out = 0, t_resp = 0;

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkv(string tag, line_t obs, line_t exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic line_t line_of(bit [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a ^ 32'hDEAD_0000, ~a, a + 32'h1111_1111, a[15:0], 16'hBEEF};
  endfunction

  task automatic push0(logic [31:0] a);
    txn_t t;
    t.id = 1'b0; t.addr = a; t.write = 1'b0; t.wdata = '0;
    q0.push_back(t);
  endtask

  task automatic push1(logic [31:0] a, logic w, line_t d);
    txn_t t;
    t.id = 1'b1; t.addr = a; t.write = w; t.wdata = d;
    q1.push_back(t);
  endtask

  // One clock cycle: check outputs against the model, drive requesters/memory, advance the model.
  task automatic step();
    bit v0, v1, er0, er1, do_out;
    @(negedge clk);
    cyc++;
    chk1("resp0", bus.req0_resp_valid, resp_due && resp_id == 1'b0);
    chk1("resp1", bus.req1_resp_valid, resp_due && resp_id == 1'b1);
    if (resp_due) begin
      chk1("grant_id", bus.grant_id, resp_id);
      t_resp = cyc;
    end
    resp_due = 1'b0;
    chkv("rdata0", bus.req0_rdata, exp_rd0);
    chkv("rdata1", bus.req1_rdata, exp_rd1);
    chk1("busy", bus.busy, phase != 0);
    chk1("mem_valid", bus.mem_is_input_valid, phase == 1);
    if (phase == 1) begin
      chkv("mem_addr", line_t'(bus.mem_addr), line_t'(cur.addr));
      chk1("mem_read", bus.mem_read, !cur.write);
      chk1("mem_write", bus.mem_write, cur.write);
      if (cur.write) chkv("mem_din", bus.mem_din, cur.wdata);
    end
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    bus.req0_valid = v0;
    bus.req0_addr  = v0 ? q0[0].addr : $urandom;
    bus.req1_valid = v1;
    bus.req1_addr  = v1 ? q1[0].addr : $urandom;
    bus.req1_write = v1 ? q1[0].write : 1'($urandom);
    bus.req1_wdata = v1 ? q1[0].wdata : rand_line();
    er0 = (phase == 0) && v0 && (!v1 || last);
    er1 = (phase == 0) && v1 && (!v0 || !last);
    bus.mem_ready = (int'($urandom_range(99)) < rdy_pct);
    do_out = (phase == 2 && cnt == 0) || (phase != 2 && spur && $urandom_range(3) == 0);
    bus.mem_is_output_valid = do_out;
    bus.mem_dout = (phase == 2 && !cur.write) ? line_of(cur.addr) : rand_line();
    #1;
    chk1("ready0", bus.req0_ready, er0);
    chk1("ready1", bus.req1_ready, er1);
    @(posedge clk);
    if (phase == 2) begin
      if (do_out) begin
        if (cur.write) mem_m[cur.addr] = cur.wdata;
        else if (cur.id) exp_rd1 = line_of(cur.addr);
        else exp_rd0 = line_of(cur.addr);
        last = cur.id;
        resp_due = 1'b1;
        resp_id = cur.id;
        phase = 0;
        t_out = cyc;
      end else begin
        cnt--;
      end
    end else if (phase == 1) begin
      if (bus.mem_ready) begin
        phase = 2;
        cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(3));
        t_cmd = cyc;
      end
    end else if (er0 || er1) begin
      if (er0) cur = q0.pop_front();
      else     cur = q1.pop_front();
      phase = 1;
      t_acc = cyc;
      served.push_back(cur);
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || phase != 0 || resp_due) && n < budget) begin
      step();
      n++;
    end
    chk1("drain_idle", (q0.size() == 0) && (q1.size() == 0) && (phase == 0), 1'b1);
  endtask

  initial begin
    int n;
    line_t a5_line, x55_line;
    a5_line  = {16{8'hA5}};
    x55_line = {16{8'h55}};

    // Reset state, with requests and a spurious reply already present.
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h1;
    bus.req1_valid = 1'b1; bus.req1_addr = 32'h2; bus.req1_write = 1'b1; bus.req1_wdata = rand_line();
    bus.mem_ready = 1'b1; bus.mem_is_output_valid = 1'b1; bus.mem_dout = rand_line();
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_ready0", bus.req0_ready, 1'b0);
    chk1("rst_ready1", bus.req1_ready, 1'b0);
    chk1("rst_resp0", bus.req0_resp_valid, 1'b0);
    chk1("rst_resp1", bus.req1_resp_valid, 1'b0);
    chk1("rst_mem_valid", bus.mem_is_input_valid, 1'b0);
    chk1("rst_mem_read", bus.mem_read, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_grant_id", bus.grant_id, 1'b0);
    chkv("rst_rdata0", bus.req0_rdata, '0);
    chkv("rst_rdata1", bus.req1_rdata, '0);
    chkv("rst_mem_addr", line_t'(bus.mem_addr), '0);
    chkv("rst_mem_din", bus.mem_din, '0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.mem_is_output_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Tie from reset: req0, then req1, then req0 again.
    lat_fixed = 1;
    push0(32'h100); push0(32'h101); push1(32'h200, 1'b0, '0);
    served.delete();
    drain(100);
    chk1("rr_first", served[0].id, 1'b0);
    chk1("rr_second", served[1].id, 1'b1);
    chk1("rr_third", served[2].id, 1'b0);

    // Single read of 0x10 returning 0xA5.. three cycles after the command.
    mem_m[32'h10] = a5_line;
    lat_fixed = 2;
    push0(32'h10);
    drain(50);
    chkv("lat_cmd", line_t'(t_cmd), line_t'(t_acc + 1));
    chkv("lat_out", line_t'(t_out), line_t'(t_cmd + 3));
    chkv("lat_resp", line_t'(t_resp), line_t'(t_out + 1));
    chkv("rdata_a5", bus.req0_rdata, a5_line);

    // Write-back from req1 leaves its read data untouched.
    lat_fixed = 1;
    push1(32'h20, 1'b1, x55_line);
    drain(50);
    chkv("wb_rdata1", bus.req1_rdata, line_t'(line_of(32'h200)));
    chkv("wb_mem", line_of(32'h20), x55_line);

    // Memory stalls the command for four cycles.
    rdy_pct = 0;
    push1(32'h30, 1'b0, '0);
    n = 0;
    while (phase != 1 && n < 10) begin step(); n++; end
    repeat (4) step();
    #1;
    chk1("stall_valid", bus.mem_is_input_valid, 1'b1);
    chkv("stall_addr", line_t'(bus.mem_addr), line_t'(32'h30));
    rdy_pct = 100;
    drain(50);

    // Reset while waiting for the reply, then a late reply.
    lat_fixed = 5;
    push0(32'h40);
    n = 0;
    while (phase != 2 && n < 10) begin step(); n++; end
    @(negedge clk);
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_resp0", bus.req0_resp_valid, 1'b0);
    chk1("abort_mem_valid", bus.mem_is_input_valid, 1'b0);
    chkv("abort_rdata0", bus.req0_rdata, '0);
    phase = 0; last = 1'b1; resp_due = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    @(negedge clk);
    reset = 1'b1;
    bus.mem_is_output_valid = 1'b1;
    bus.mem_dout = rand_line();
    @(posedge clk);
    lat_fixed = 1;
    push0(32'h50); push1(32'h60, 1'b1, rand_line());
    served.delete();
    drain(100);
    chk1("post_rst_first", served[0].id, 1'b0);
    chk1("post_rst_second", served[1].id, 1'b1);

    // Spurious replies while idle.
    spur = 1'b1;
    repeat (8) step();

    // Randomized traffic over a small address pool so writes are read back.
    lat_fixed = -1;
    rdy_pct = 60;
    for (int i = 0; i < 300; i++) begin
      if (q0.size() < 3 && $urandom_range(2) == 0) push0(32'h0 + $urandom_range(15));
      if (q1.size() < 3 && $urandom_range(2) == 0)
        push1(32'h0 + $urandom_range(15), 1'($urandom), rand_line());
      step();
    end
    drain(500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LINE_SIZE, default 16, line size in bytes; LW = 8*LINE_SIZE is the line data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-004 req0_valid  input  1  requester 0 (instruction-side refill) read request.
REQ-005 req0_addr  input  32  requester 0 line address, already shifted by CLOG2(LINE_SIZE).
REQ-006 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-007 req0_resp_valid  output  1  one-cycle pulse: req0_rdata valid.
REQ-008 req0_rdata  output  LW  requester 0 read line.
REQ-009 req1_valid  input  1  requester 1 (data-side) request.
REQ-010 req1_addr  input  32  requester 1 line address, already shifted.
REQ-011 req1_write  input  1  1 = write-back, 0 = refill read.
REQ-012 req1_wdata  input  LW  requester 1 write line.
REQ-013 req1_ready, req1_resp_valid, req1_rdata  output  1/1/LW  same meaning as the requester 0 signals.
REQ-014 mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din  output  1/32/1/1/LW  memory command.
REQ-015 mem_ready, mem_is_output_valid, mem_dout  input  1/1/LW  memory accept, completion and read data.
REQ-016 busy  output  1  FSM not in IDLE; grant_id  output  1  owner of the current or last transaction.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT; exactly one state active.
REQ-018 IDLE: if exactly one reqN_valid, that requester wins; if both valid, the requester other than last_grant wins (round-robin).
REQ-019 reqN_ready is combinational: 1 only in IDLE for the winning requester; accept = reqN_valid & reqN_ready.
REQ-020 On accept: latch addr, write (0 for req0), and wdata; set grant_id; next state ISSUE.
REQ-021 ISSUE: mem_is_input_valid = 1 with latched fields; mem_read = ~write, mem_write = write; stay in ISSUE while mem_ready = 0; exit to WAIT after a cycle with mem_ready = 1.
REQ-022 mem_is_input_valid, mem_read, mem_write = 0 outside ISSUE; mem_addr and mem_din hold latched values.
REQ-023 WAIT: on mem_is_output_valid = 1, capture mem_dout into the granted reqN_rdata (reads only; writes leave rdata unchanged), pulse reqN_resp_valid for exactly the next cycle, set last_grant = grant_id, go IDLE.
REQ-024 Latency: accept at cycle T, memory command at T+1 if mem_ready = 1, resp_valid one cycle after mem_is_output_valid.
REQ-025 The resp_valid cycle is spent in IDLE, so a new accept may occur in that same cycle; at most one transaction is outstanding.
REQ-026 mem_is_output_valid is ignored in IDLE and ISSUE.
REQ-027 reqN_valid dropping after accept does not cancel the transaction.
REQ-028 reqN_rdata holds its value until the next read response to that requester.
REQ-029 The non-winning requester's ready = 0; its request waits, and round-robin bounds its wait to one transaction.

Reset
REQ-030 While reset = 0: state = IDLE, last_grant = 1 (req0 wins the first tie), grant_id = 0, all ready/valid/resp outputs = 0, rdata/mem_addr/mem_din = 0, busy = 0.
REQ-031 Reset asserted mid-transaction aborts it immediately: no resp_valid pulse, and a late mem_is_output_valid is ignored.

Verification
REQ-032 Only req0_valid with addr 0x10, mem_ready = 1, memory returns 0xA5.. after 3 cycles -> req0_ready at T, mem_read at T+1, req0_resp_valid 1 cycle with rdata 0xA5...
REQ-033 req0 and req1 both valid from reset -> req0 served first, req1 second, then req0 again if both are still valid.
REQ-034 req1 write of 0x55.. to 0x20 -> mem_write = 1, mem_din = 0x55.., req1_resp_valid pulse, req1_rdata unchanged.
REQ-035 mem_ready held 0 for 4 cycles during ISSUE -> mem_is_input_valid stays 1 with stable addr, and the FSM leaves ISSUE only after mem_ready = 1.
REQ-036 reset = 0 during WAIT, then released, then memory asserts mem_is_output_valid -> no resp_valid pulse, busy = 0, next request is served normally.
REQ-037 Spurious mem_is_output_valid in IDLE -> no output change.
